// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit MIPS multiply/divide unit with private HI/LO
// Shift-add multiply and restoring divide on magnitudes, sign-corrected in the FINAL cycle.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        write_hi,
    input  logic        write_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [31:0] r_a_raw;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic        w_signed;
    logic        w_sign_a;
    logic        w_sign_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_trial;
    logic [63:0] w_div_next;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_signed = ~op[0];
    assign w_sign_a = w_signed & operand_a[31];
    assign w_sign_b = w_signed & operand_b[31];
    assign w_abs_a  = w_sign_a ? (~operand_a + 32'd1) : operand_a;
    assign w_abs_b  = w_sign_b ? (~operand_b + 32'd1) : operand_b;

    // Multiply: multiplier sits in acc[31:0]; multiplicand added into the upper half.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};

    // Divide: trial-subtract on the upper 33 bits of the left-shifted {rem, quo}.
    assign w_div_trial = r_acc[63:31] - {1'b0, r_opnd};
    assign w_div_next  = w_div_trial[32] ? {r_acc[62:0], 1'b0}
                                         : {w_div_trial[31:0], r_acc[30:0], 1'b1};

    assign w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
    assign w_quo  = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ITER;
            S_ITER:  if (r_cnt == 5'd31) w_next = S_FINAL;
            S_FINAL: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_acc    <= 64'd0;
            r_opnd   <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_a_raw  <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div <= op[1];
                        r_acc    <= {32'd0, op[1] ? w_abs_a : w_abs_b};
                        r_opnd   <= op[1] ? w_abs_b : w_abs_a;
                        r_neg_q  <= w_sign_a ^ w_sign_b;
                        r_neg_r  <= w_sign_a;
                        r_div0   <= op[1] & (operand_b == 32'd0);
                        r_a_raw  <= operand_a;
                        r_cnt    <= 5'd0;
                        r_busy   <= 1'b1;
                    end else begin
                        if (write_hi) r_hi <= operand_a;
                        if (write_lo) r_lo <= operand_a;
                    end
                end
                S_ITER: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FINAL: begin
                    if (!r_is_div) begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end else if (r_div0) begin
                        r_hi <= r_a_raw;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        write_hi;
    logic        write_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .write_hi  (write_hi),
        .write_lo  (write_lo),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch an op, scramble operands after E0, count busy cycles until done.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int nbusy;
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(negedge clk);
        start = 1'b0; operand_a = 32'hDEAD_BEEF; operand_b = 32'h0BAD_F00D; op = ~o;
        nbusy = 0;
        cyc = 0;
        while (!done && cyc < 100) begin
            if (busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " done_seen"}, {31'd0, done}, 32'd1);
        check({tag, " busy_cycles"}, nbusy, 32'd33);
        check({tag, " busy_with_done"}, {31'd0, busy}, 32'd0);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        @(negedge clk);
        check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int saw_done;
        reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = 32'd0; operand_b = 32'd0;
        write_hi = 1'b0; write_lo = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_big_2", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
        run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        run_op("div_by0_neg", OP_DIV, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFF6, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

        // MTHI / MTLO in IDLE
        @(negedge clk);
        write_hi = 1'b1; operand_a = 32'h1234_5678;
        @(negedge clk);
        write_hi = 1'b0; write_lo = 1'b1; operand_a = 32'h9ABC_DEF0;
        check("mthi hi", hi, 32'h1234_5678);
        check("mthi no_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        write_lo = 1'b0;
        check("mtlo lo", lo, 32'h9ABC_DEF0);
        check("mtlo hi_held", hi, 32'h1234_5678);
        check("mtlo no_done", {31'd0, done}, 32'd0);
        write_hi = 1'b1; write_lo = 1'b1; operand_a = 32'h0F0F_0F0F;
        @(negedge clk);
        write_hi = 1'b0; write_lo = 1'b0;
        check("mt_both hi", hi, 32'h0F0F_0F0F);
        check("mt_both lo", lo, 32'h0F0F_0F0F);

        // start wins over write_hi in the same IDLE cycle
        start = 1'b1; op = OP_MULTU; operand_a = 32'd5; operand_b = 32'd6; write_hi = 1'b1;
        @(negedge clk);
        start = 1'b0; write_hi = 1'b0;
        check("start_prio hi", hi, 32'h0F0F_0F0F);
        check("start_prio busy", {31'd0, busy}, 32'd1);
        repeat (5) @(negedge clk);
        // writes and a second start during busy are ignored
        start = 1'b1; write_hi = 1'b1; write_lo = 1'b1; op = OP_DIVU; operand_a = 32'h7777_7777;
        operand_b = 32'd3;
        repeat (3) @(negedge clk);
        start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
        check("busy_write hi", hi, 32'h0F0F_0F0F);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_ign done", {31'd0, done}, 32'd1);
        check("busy_ign hi", hi, 32'd0);
        check("busy_ign lo", lo, 32'd30);
        @(negedge clk);
        check("busy_ign idle", {31'd0, busy}, 32'd0);

        // reset sampled at E10 of a DIV
        run_op("pre_reset", OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd81);
        start = 1'b1; op = OP_DIV; operand_a = 32'd1000; operand_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset busy", {31'd0, busy}, 32'd0);
        check("mid_reset hi", hi, 32'd0);
        check("mid_reset lo", lo, 32'd0);
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check("mid_reset no_done", saw_done, 32'd0);
        run_op("post_reset", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the 32-bit MIPS datapath. It sits directly downstream of the register block and consumes its two read ports: rs feeds operand_a, rt feeds operand_b. It executes MULT, MULTU, DIV and DIVU into private HI/LO registers over a fixed multi-cycle schedule, and it services MTHI/MTLO writes. The control path reads HI/LO for MFHI/MFLO and stalls the pipeline on busy.

## Interface
Parameters:
- none (width fixed at 32, iteration count fixed at 32)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  begin operation selected by op; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- operand_a  input  32  rs value from register block read_data1; multiplicand / dividend
- operand_b  input  32  rt value from register block read_data2; multiplier / divisor
- write_hi  input  1  MTHI: load HI from operand_a
- write_lo  input  1  MTLO: load LO from operand_a
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  operation in progress; HI/LO not yet valid
- done  output  1  one-cycle pulse: HI/LO just updated by an operation

## Operation
- States: IDLE, ITER, FINAL.
- IDLE, start=1:
  - Latch op.
  - For signed ops, latch absolute values of operands plus result-sign flags. Product sign = sign_a XOR sign_b. Quotient sign = sign_a XOR sign_b. Remainder sign = sign_a.
  - Clear the 5-bit counter and go to ITER.
- ITER, multiply: shift-add on unsigned magnitudes. 64-bit accumulator; each step conditionally adds the multiplicand into the upper half and shifts right 1.
- ITER, divide: restoring division. 64-bit {remainder, quotient} shift-left; subtract divisor from the upper 33 bits; keep the result if non-negative and set quotient bit 1, else restore and set 0.
- ITER lasts exactly 32 cycles. When counter reaches 31, go to FINAL.
- FINAL:
  - Apply two's-complement sign correction:
    - Multiply: negate the full 64-bit product as one value.
    - Divide: negate quotient and remainder independently.
  - Write HI/LO, pulse done, return to IDLE.
  - Multiply result: HI = product[63:32], LO = product[31:0].
  - Divide result: LO = quotient, HI = remainder.
- Divide by zero (operand_b == 0, detected at start): still runs the full schedule. Result is LO = 32'hFFFFFFFF, HI = operand_a as latched, unaltered, regardless of signedness.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (natural wrap; no trap).
- MTHI/MTLO:
  - Honoured only in IDLE with start=0. Register updates at the next edge.
  - write_hi and write_lo both high: both load operand_a.
- start in the same IDLE cycle as write_hi/write_lo: start has priority, writes ignored.
- start, write_hi and write_lo are ignored in ITER and FINAL.
- Operand inputs are don't-care after the start edge; no dependence on register block stability.
- HI/LO hold their value in all other cycles.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, state IDLE, counter 0.
- Reset at any point, including mid-ITER, aborts the operation and applies these values at that edge. A pending result is discarded.
- Let E0 be the edge that samples start=1 in IDLE.
  - busy = 1 from E0 until E33.
  - Iteration edges are E1 through E32.
  - E33 (FINAL) writes HI/LO, sets busy = 0 and done = 1.
  - done returns to 0 at E34 unless re-triggered. Total latency start-to-result is 33 cycles.
- busy is a registered output, high in states ITER and FINAL. done is registered and never high together with busy.
- A new start is accepted in the cycle done is high; back-to-back throughput is one operation per 34 cycles.
- MTHI/MTLO latency: one edge, with no done pulse.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001. busy high for exactly 33 cycles; done pulses once at E33.
- MULT −3 (0xFFFFFFFD) × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
- DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> LO = 0x7FFFFFFC, HI = 1.
- DIVU 100 / 0 -> LO = 0xFFFFFFFF, HI = 100. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Sequence:
  - MTHI 0x12345678 and MTLO 0x9ABCDEF0 in IDLE -> visible next cycle, no done.
  - Start MULTU 5×6, then during busy assert write_hi and a second start -> both ignored; final HI = 0, LO = 30.
- Reset asserted at E10 of a DIV -> same edge busy = 0, hi = lo = 0, done never pulses. Next start of MULTU 3×4 -> LO = 12 at its own E33.
